// File: rtl/cordic_rot_engine.sv
// cordic_rot_engine: iterative CORDIC rotation, one micro-rotation per clock
module cordic_rot_engine #(
   parameter int ITER = 12
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] x_in,
   input  logic [15:0] y_in,
   input  logic [15:0] z_in,
   output logic        busy,
   output logic        done,
   output logic [17:0] x_out,
   output logic [17:0] y_out,
   output logic [15:0] z_out,
   output logic [11:0] dir,
   output logic        quad
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [15:0] ATAN [12] = '{16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326,
                                          16'd163, 16'd81, 16'd41, 16'd20, 16'd10, 16'd5};
   state_t             state_q, state_d;
   logic               busy_q, busy_d, done_q, done_d, quad_q, quad_d, flip;
   logic [3:0]         cnt_q, cnt_d;
   logic signed [17:0] x_q, x_d, y_q, y_d, xs, ys, x_ld, y_ld;
   logic [15:0]        z_q, z_d, a;
   logic [11:0]        dir_q, dir_d;
   // next-state: load on an accepted start, otherwise one micro-rotation per RUN cycle
   always_comb begin
      flip = z_in[15] ^ z_in[14];
      x_ld = {{2{x_in[15]}}, x_in};
      y_ld = {{2{y_in[15]}}, y_in};
      xs = x_q >>> cnt_q;
      ys = y_q >>> cnt_q;
      a = ATAN[cnt_q];
      state_d = state_q;
      busy_d = busy_q;
      done_d = 1'b0;
      quad_d = quad_q;
      cnt_d = cnt_q;
      x_d = x_q;
      y_d = y_q;
      z_d = z_q;
      dir_d = dir_q;
      if (state_q == RUN) begin
         x_d = z_q[15] ? x_q + ys : x_q - ys;
         y_d = z_q[15] ? y_q - xs : y_q + xs;
         z_d = z_q[15] ? z_q + a : z_q - a;
         dir_d[cnt_q] = z_q[15];
         cnt_d = cnt_q + 4'd1;
         if (cnt_q == 4'(ITER - 1)) begin
            state_d = DONE;
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end else if (start) begin
         state_d = RUN;
         busy_d = 1'b1;
         cnt_d = 4'd0;
         dir_d = 12'd0;
         quad_d = flip;
         x_d = flip ? -x_ld : x_ld;
         y_d = flip ? -y_ld : y_ld;
         z_d = flip ? z_in ^ 16'h8000 : z_in;
      end else begin
         state_d = IDLE;
      end
   end
   // state and working registers; reset clears everything immediately
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         quad_q <= 1'b0;
         cnt_q <= 4'd0;
         x_q <= '0;
         y_q <= '0;
         z_q <= '0;
         dir_q <= '0;
      end else begin
         state_q <= state_d;
         busy_q <= busy_d;
         done_q <= done_d;
         quad_q <= quad_d;
         cnt_q <= cnt_d;
         x_q <= x_d;
         y_q <= y_d;
         z_q <= z_d;
         dir_q <= dir_d;
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign x_out = x_q;
   assign y_out = y_q;
   assign z_out = z_q;
   assign dir = dir_q;
   assign quad = quad_q;
endmodule

// File: tb/tb_cordic_rot_engine.sv
// tb_cordic_rot_engine: directed table, handshake/reset sequences and random ops against a reference model
module tb_cordic_rot_engine;
   logic clock = 0, reset = 1, start_a = 0, start_b = 0, sel = 0;
   logic [15:0] x_in = 0, y_in = 0, z_in = 0;
   logic busy_a, done_a, quad_a, busy_b, done_b, quad_b;
   logic [17:0] x_a, y_a, x_b, y_b;
   logic [15:0] z_a, z_b;
   logic [11:0] dir_a, dir_b;
   logic o_busy, o_done, o_quad;
   logic [17:0] o_x, o_y;
   logic [15:0] o_z;
   logic [11:0] o_dir;
   int checks = 0, errors = 0;

   cordic_rot_engine #(.ITER(12)) dut_a (.clock(clock), .reset(reset), .start(start_a), .x_in(x_in), .y_in(y_in),
      .z_in(z_in), .busy(busy_a), .done(done_a), .x_out(x_a), .y_out(y_a), .z_out(z_a), .dir(dir_a), .quad(quad_a));
   cordic_rot_engine #(.ITER(1)) dut_b (.clock(clock), .reset(reset), .start(start_b), .x_in(x_in), .y_in(y_in),
      .z_in(z_in), .busy(busy_b), .done(done_b), .x_out(x_b), .y_out(y_b), .z_out(z_b), .dir(dir_b), .quad(quad_b));

   always #5 clock = ~clock;

   assign o_busy = sel ? busy_b : busy_a;
   assign o_done = sel ? done_b : done_a;
   assign o_quad = sel ? quad_b : quad_a;
   assign o_x = sel ? x_b : x_a;
   assign o_y = sel ? y_b : y_a;
   assign o_z = sel ? z_b : z_a;
   assign o_dir = sel ? dir_b : dir_a;

   typedef struct {int x; int y; int z; logic [11:0] dir; logic quad;} res_t;
   typedef struct {int x; int y; int z; int ex; int ey; int q;} vec_t;

   // angle-domain reference: fold into +-90 deg, then n greedy micro-rotations toward zero residual
   function automatic res_t model(int xi, int yi, int zi, int n);
      int atan_tab[12] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5};
      res_t r;
      int x, y, z, xt;
      r.dir = 12'd0;
      r.quad = (zi >= 16384 || zi < -16384);
      x = r.quad ? -xi : xi;
      y = r.quad ? -yi : yi;
      z = r.quad ? (zi >= 0 ? zi - 32768 : zi + 32768) : zi;
      for (int i = 0; i < n; i++) begin
         r.dir[i] = (z < 0);
         xt = x;
         x = (z < 0) ? x + (y >>> i) : x - (y >>> i);
         y = (z < 0) ? y - (xt >>> i) : y + (xt >>> i);
         z = (z < 0) ? z + atan_tab[i] : z - atan_tab[i];
      end
      r.x = int'($signed(18'(x)));
      r.y = int'($signed(18'(y)));
      r.z = int'($signed(16'(z)));
      return r;
   endfunction

   task automatic chk(string nm, int act, int exp, int tol);
      checks++;
      if (act > exp + tol || act < exp - tol) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (tol %0d)", nm, act, exp, tol);
      end
   endtask

   task automatic chk_res(string nm, res_t r);
      chk({nm, "_x"}, int'($signed(o_x)), r.x, 0);
      chk({nm, "_y"}, int'($signed(o_y)), r.y, 0);
      chk({nm, "_z"}, int'($signed(o_z)), r.z, 0);
      chk({nm, "_dir"}, int'(o_dir), int'(r.dir), 0);
      chk({nm, "_quad"}, int'(o_quad), int'(r.quad), 0);
   endtask

   task automatic run_op(input logic s, input int xi, input int yi, input int zi, output int lat);
      sel = s;
      @(negedge clock);
      x_in = xi[15:0];
      y_in = yi[15:0];
      z_in = zi[15:0];
      if (s) start_b = 1; else start_a = 1;
      @(posedge clock);
      #1 start_a = 0;
      start_b = 0;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clock);
         #1;
         if (o_done) begin
            lat = c;
            break;
         end
      end
   endtask

   initial begin
      vec_t tab[4];
      res_t r;
      int lat, n, first, last, dn;
      int qx[$], qy[$], qz[$];
      logic [15:0] rx, ry, rz;
      tab[0] = '{10000, 0, 0, 16468, 0, 0};
      tab[1] = '{10000, 0, 8192, 11644, 11644, 0};
      tab[2] = '{10000, 0, -16384, 0, -16468, 0};
      tab[3] = '{10000, 0, -32768, -16468, 0, 1};

      #2;
      chk("rst_busy", int'(busy_a), 0, 0);
      chk("rst_done", int'(done_a), 0, 0);
      chk("rst_x", int'(x_a), 0, 0);
      chk("rst_y", int'(y_a), 0, 0);
      chk("rst_z", int'(z_a), 0, 0);
      chk("rst_dir", int'(dir_a), 0, 0);
      chk("rst_quad", int'(quad_a), 0, 0);
      @(negedge clock);
      reset = 0;

      for (int i = 0; i < 4; i++) begin
         run_op(0, tab[i].x, tab[i].y, tab[i].z, lat);
         chk("tab_lat", lat, 12, 0);
         chk("tab_x", int'($signed(o_x)), tab[i].ex, 14);
         chk("tab_y", int'($signed(o_y)), tab[i].ey, 14);
         chk("tab_quad", int'(o_quad), tab[i].q, 0);
         chk_res("tab_model", model(tab[i].x, tab[i].y, tab[i].z, 12));
         if (i == 0) begin
            chk("zero_z", int'($signed(o_z)), 0, 5);
            chk("zero_dir0", int'(o_dir[0]), 0, 0);
         end
      end

      sel = 0;
      @(negedge clock);
      x_in = 16'd5000; y_in = 16'd3000; z_in = 16'd4000;
      start_a = 1;
      first = -1; n = 0;
      for (int c = 0; c <= 20; c++) begin
         @(posedge clock);
         #1 start_a = (c == 2);
         if (c > 0 && o_done) begin
            n++;
            if (first < 0) first = c;
         end
      end
      chk("ignore_first", first, 12, 0);
      chk("ignore_count", n, 1, 0);
      chk_res("ignore_res", model(5000, 3000, 4000, 12));

      @(negedge clock);
      rx = 16'($urandom); ry = 16'($urandom); rz = 16'($urandom);
      x_in = rx; y_in = ry; z_in = rz;
      qx.push_back(int'($signed(rx))); qy.push_back(int'($signed(ry))); qz.push_back(int'($signed(rz)));
      start_a = 1;
      dn = 0; last = -1;
      for (int c = 1; c <= 45 && dn < 3; c++) begin
         @(posedge clock);
         #1;
         if (o_done) begin
            chk_res("held", model(qx.pop_front(), qy.pop_front(), qz.pop_front(), 12));
            if (last < 0) chk("held_lat", c - 1, 12, 0);
            else chk("held_period", c - last, 13, 0);
            last = c;
            dn++;
            rx = 16'($urandom); ry = 16'($urandom); rz = 16'($urandom);
            x_in = rx; y_in = ry; z_in = rz;
            qx.push_back(int'($signed(rx))); qy.push_back(int'($signed(ry))); qz.push_back(int'($signed(rz)));
         end else if (o_busy) begin
            x_in = 16'($urandom); y_in = 16'($urandom); z_in = 16'($urandom);
         end
      end
      start_a = 0;
      chk("held_count", dn, 3, 0);
      repeat (2) @(posedge clock);

      @(negedge clock);
      x_in = 16'd9000; y_in = 16'd1000; z_in = 16'd20000;
      start_a = 1;
      @(posedge clock);
      #1 start_a = 0;
      repeat (5) @(posedge clock);
      #1 reset = 1;
      #1;
      chk("abort_busy", int'(busy_a), 0, 0);
      chk("abort_done", int'(done_a), 0, 0);
      chk("abort_x", int'(x_a), 0, 0);
      chk("abort_y", int'(y_a), 0, 0);
      chk("abort_z", int'(z_a), 0, 0);
      chk("abort_dir", int'(dir_a), 0, 0);
      chk("abort_quad", int'(quad_a), 0, 0);
      repeat (2) @(negedge clock);
      reset = 0;
      n = 0;
      repeat (15) begin
         @(posedge clock);
         #1 if (done_a) n++;
      end
      chk("abort_nodone", n, 0, 0);
      run_op(0, 9000, 1000, 20000, lat);
      chk("after_rst_lat", lat, 12, 0);
      chk_res("after_rst", model(9000, 1000, 20000, 12));

      run_op(1, 1000, 0, 0, lat);
      chk("short_lat", lat, 1, 0);
      chk("short_x", int'($signed(o_x)), 1000, 0);
      chk("short_y", int'($signed(o_y)), 1000, 0);
      chk("short_z", int'($signed(o_z)), -8192, 0);
      chk("short_dir", int'(o_dir), 0, 0);

      for (int k = 0; k < 20; k++) begin
         rx = 16'($urandom); ry = 16'($urandom); rz = 16'($urandom);
         run_op(k % 4 == 3, int'($signed(rx)), int'($signed(ry)), int'($signed(rz)), lat);
         chk("rand_lat", lat, (k % 4 == 3) ? 1 : 12, 0);
         chk_res("rand", model(int'($signed(rx)), int'($signed(ry)), int'($signed(rz)), (k % 4 == 3) ? 1 : 12));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
